// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StEcho,
        StMsg,
        StWait
    } state_e;

    localparam int unsigned MSG_LEN = 15;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

endpackage

// File: rtl/msg_rom.sv
// Combinational ROM holding the burst text "Hello, world!" followed by CR LF.
module msg_rom
    import uart_pkg::*;
(
    input  logic [3:0] idx,
    output logic [7:0] data
);

    always_comb begin
        data = 8'h00;
        case (idx)
            4'd0:    data = 8'h48;
            4'd1:    data = 8'h65;
            4'd2:    data = 8'h6C;
            4'd3:    data = 8'h6C;
            4'd4:    data = 8'h6F;
            4'd5:    data = 8'h2C;
            4'd6:    data = 8'h20;
            4'd7:    data = 8'h77;
            4'd8:    data = 8'h6F;
            4'd9:    data = 8'h72;
            4'd10:   data = 8'h6C;
            4'd11:   data = 8'h64;
            4'd12:   data = 8'h21;
            4'd13:   data = CR;
            4'd14:   data = LF;
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates a one-entry echo buffer and a periodic message burst onto a UART transmitter.
// Define UART_TX_ARB_OVF_EN to build the sticky echo-overflow flag; otherwise ovf is tied low.
module uart_tx_arb #(
    parameter int unsigned PERIOD  = 100000000,
    parameter int unsigned MSG_LEN = uart_pkg::MSG_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ack,
    input  logic       tx_rdy,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    output logic       busy,
    output logic       ovf
);

    import uart_pkg::state_e;
    import uart_pkg::StIdle;
    import uart_pkg::StEcho;
    import uart_pkg::StMsg;
    import uart_pkg::StWait;

    localparam logic [26:0] PeriodLast = 27'(PERIOD - 1);
    localparam logic [3:0]  IdxLast    = 4'(MSG_LEN - 1);

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    logic        wait_first_q, wait_first_d;
    logic [3:0]  idx_q, idx_d;
    logic [26:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic        rx_prev_q;

    logic [7:0]  rom_data;
    logic        rx_rise;
    logic        drain;
    logic        capture;
    logic        last_wr;
    logic        wr;
    logic [7:0]  wr_data;

    msg_rom u_msg_rom (
        .idx  (idx_q),
        .data (rom_data)
    );

    assign rx_rise = rx_valid & ~rx_prev_q;
    assign drain   = (state_q == StEcho) & tx_rdy & ~rst;
    // A drain in the same cycle frees the entry, so the new byte is still accepted.
    assign capture = rx_rise & (~buf_full_q | drain);

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        wait_first_d = wait_first_q;
        idx_d        = idx_q;
        last_wr      = 1'b0;
        wr           = 1'b0;
        wr_data      = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (pending_q && tx_rdy) begin
                    state_d = StMsg;
                end else if (buf_full_q && tx_rdy) begin
                    state_d = StEcho;
                end
            end
            StEcho: begin
                if (tx_rdy) begin
                    wr           = 1'b1;
                    wr_data      = buf_q;
                    ret_d        = StIdle;
                    state_d      = StWait;
                    wait_first_d = 1'b1;
                end
            end
            StMsg: begin
                if (tx_rdy) begin
                    wr           = 1'b1;
                    wr_data      = rom_data;
                    state_d      = StWait;
                    wait_first_d = 1'b1;
                    if (idx_q < IdxLast) begin
                        idx_d = idx_q + 4'd1;
                        ret_d = StMsg;
                    end else begin
                        idx_d   = 4'd0;
                        ret_d   = StIdle;
                        last_wr = 1'b1;
                    end
                end
            end
            StWait: begin
                // The transmitter may not have dropped tx_rdy yet in the first cycle.
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (tx_rdy) begin
                    state_d = ret_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (!mode) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end else begin
            if (cnt_q == PeriodLast) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 27'd1;
            end
            // A tick while a burst is still pending is lost.
            if (pending_q) begin
                pending_d = ~last_wr;
            end else begin
                pending_d = (cnt_q == PeriodLast);
            end
        end
    end

    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (drain) begin
            buf_full_d = 1'b0;
        end
        if (capture) begin
            buf_d      = rx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ret_q        <= StIdle;
            wait_first_q <= 1'b0;
            idx_q        <= 4'd0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            buf_q        <= 8'h00;
            buf_full_q   <= 1'b0;
            rx_prev_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            wait_first_q <= wait_first_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            rx_prev_q    <= rx_valid;
        end
    end

`ifdef UART_TX_ARB_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (rx_rise && !capture) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // Strobes are gated by rst so an abort takes effect in the cycle it is asserted.
    assign tx_wr   = wr & ~rst;
    assign tx_data = rst ? 8'h00 : wr_data;
    assign rx_ack  = capture & ~rst;
    assign busy    = buf_full_q | (state_q == StMsg) |
                     ((state_q == StWait) && (ret_q == StMsg));

endmodule
